// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage: load-mask encodings,
// FSM state encoding and the exception flag bundle carried from EX to WB.
package mem_stage_pkg;

   localparam int XLEN_DEF          = 32;
   localparam int RF_ADDR_WIDTH_DEF = 5;

   localparam int L_LB  = 0;
   localparam int L_LBU = 1;
   localparam int L_LH  = 2;
   localparam int L_LHU = 3;
   localparam int L_LW  = 4;

   localparam logic [4:0] LM_LB  = 5'(1 << L_LB);
   localparam logic [4:0] LM_LBU = 5'(1 << L_LBU);
   localparam logic [4:0] LM_LH  = 5'(1 << L_LH);
   localparam logic [4:0] LM_LHU = 5'(1 << L_LHU);
   localparam logic [4:0] LM_LW  = 5'(1 << L_LW);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } mem_state_e;

   typedef struct packed {
      logic exp_flag;
      logic int_flag;
      logic inst_addr_misal;
      logic illg_inst;
      logic ecall_inst;
      logic ebreak_inst;
   } ex_flags_t;

   // Halfword loads need an even address, word loads a word-aligned one.
   function automatic logic load_misal(input logic [4:0] l_mask, input logic [1:0] addr_2low);
      return ((l_mask[L_LH] | l_mask[L_LHU]) & addr_2low[0]) |
             (l_mask[L_LW] & (addr_2low != 2'b00));
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory read bus between the MEM stage (master) and the memory (slave).
interface mem_stage_if
   import mem_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
);
   logic            dmem_req_valid;
   logic            dmem_req_ready;
   logic [XLEN-1:0] dmem_addr;
   logic            dmem_rsp_valid;
   logic [XLEN-1:0] dmem_rsp_rdata;

   modport master (
      output dmem_req_valid,
      output dmem_addr,
      input  dmem_req_ready,
      input  dmem_rsp_valid,
      input  dmem_rsp_rdata
   );

   modport slave (
      input  dmem_req_valid,
      input  dmem_addr,
      output dmem_req_ready,
      output dmem_rsp_valid,
      output dmem_rsp_rdata
   );
endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: picks the addressed byte/halfword out of the
// read word and sign- or zero-extends it according to the one-hot load mask.
module mem_stage_load_align
   import mem_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
)(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr_2low,
   input  logic [4:0]      l_mask,
   output logic [XLEN-1:0] wdata
);

   logic [7:0]  lane [XLEN/8];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   for (genvar gi = 0; gi < XLEN/8; gi++) begin : g_lane
      assign lane[gi] = rdata[8*gi +: 8];
   end

   assign byte_sel = lane[addr_2low];
   assign half_sel = {lane[{addr_2low[1], 1'b1}], lane[{addr_2low[1], 1'b0}]};

   // Anything other than exactly one mask bit yields zero.
   always_comb begin
      wdata = '0;
      case (l_mask)
         LM_LB:   wdata = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         LM_LBU:  wdata = {{(XLEN-8){1'b0}}, byte_sel};
         LM_LH:   wdata = {{(XLEN-16){half_sel[15]}}, half_sel};
         LM_LHU:  wdata = {{(XLEN-16){1'b0}}, half_sel};
         LM_LW:   wdata = rdata;
         default: wdata = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX->MEM and MEM->WB valid/allowin handshakes,
// load request/response sequencing on the data bus, and registered WB outputs.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int XLEN          = XLEN_DEF,
   parameter int RF_ADDR_WIDTH = RF_ADDR_WIDTH_DEF
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ex_mem_valid,
   output logic                     mem_allowin,
   input  logic                     mem_flush,
   input  logic [XLEN-1:0]          mem_pc,
   input  logic [XLEN-1:0]          mem_inst,
   input  logic                     mem_req_rf,
   input  logic [RF_ADDR_WIDTH-1:0] mem_rf_waddr,
   input  logic [XLEN-1:0]          mem_alu_res,
   input  logic                     mem_is_load,
   input  logic [1:0]               mem_ls_addr_2low,
   input  logic [4:0]               mem_l_mask,
   input  logic                     ex2mem_exp_flag,
   input  logic                     ex2mem_int_flag,
   input  logic                     ex2mem_inst_addr_misal,
   input  logic                     ex2mem_illg_inst,
   input  logic                     ex2mem_ecall_inst,
   input  logic                     ex2mem_ebreak_inst,
   mem_stage_if.master              dmem,
   input  logic                     wb_allowin,
   output logic                     mem_wb_valid,
   output logic [XLEN-1:0]          wb_pc,
   output logic [XLEN-1:0]          wb_inst,
   output logic                     wb_req_rf,
   output logic [RF_ADDR_WIDTH-1:0] wb_rf_waddr,
   output logic [XLEN-1:0]          wb_rf_wdata,
   output logic                     mem2wb_exp_flag,
   output logic                     mem2wb_int_flag,
   output logic                     mem2wb_inst_addr_misal,
   output logic                     mem2wb_illg_inst,
   output logic                     mem2wb_ecall_inst,
   output logic                     mem2wb_ebreak_inst,
   output logic                     mem2wb_load_addr_misal
);

   mem_state_e state_reg, state_next;
   logic       mem_valid_reg;
   logic       ready_go;
   logic       req_valid;
   logic       capture;
   logic       misal;
   logic       load_ok;
   logic       fire_wb;
   ex_flags_t  ex_flags;

   logic [XLEN-1:0] align_wdata;
   logic [XLEN-1:0] result;
   logic [XLEN-1:0] hold_data_reg;

   logic [XLEN-1:0]          wb_pc_reg;
   logic [XLEN-1:0]          wb_inst_reg;
   logic                     wb_req_rf_reg;
   logic [RF_ADDR_WIDTH-1:0] wb_rf_waddr_reg;
   logic [XLEN-1:0]          wb_rf_wdata_reg;
   ex_flags_t                wb_flags_reg;
   logic                     wb_misal_reg;

   assign ex_flags = '{
      exp_flag:        ex2mem_exp_flag,
      int_flag:        ex2mem_int_flag,
      inst_addr_misal: ex2mem_inst_addr_misal,
      illg_inst:       ex2mem_illg_inst,
      ecall_inst:      ex2mem_ecall_inst,
      ebreak_inst:     ex2mem_ebreak_inst
   };

   assign misal   = mem_is_load & load_misal(mem_l_mask, mem_ls_addr_2low);
   assign load_ok = mem_valid_reg & mem_is_load & ~misal &
                    ~ex_flags.exp_flag & ~ex_flags.int_flag & ~ex_flags.illg_inst;

   mem_stage_load_align #(
      .XLEN (XLEN)
   ) u_load_align (
      .rdata     (dmem.dmem_rsp_rdata),
      .addr_2low (mem_ls_addr_2low),
      .l_mask    (mem_l_mask),
      .wdata     (align_wdata)
   );

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // A flush while waiting must still swallow the outstanding response (DRAIN).
   always_comb begin
      state_next = state_reg;
      ready_go   = 1'b0;
      req_valid  = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            req_valid = load_ok;
            ready_go  = ~load_ok;
            if (load_ok && dmem.dmem_req_ready && !mem_flush) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            ready_go = dmem.dmem_rsp_valid;
            if (mem_flush) begin
               state_next = dmem.dmem_rsp_valid ? ST_IDLE : ST_DRAIN;
            end else if (dmem.dmem_rsp_valid) begin
               state_next = wb_allowin ? ST_IDLE : ST_HOLD;
               capture    = ~wb_allowin;
            end
         end
         ST_HOLD: begin
            ready_go = 1'b1;
            if (wb_allowin || mem_flush) begin
               state_next = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (dmem.dmem_rsp_valid) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign dmem.dmem_req_valid = req_valid;
   assign dmem.dmem_addr      = {mem_alu_res[XLEN-1:2], 2'b00};

   assign mem_allowin  = (state_reg != ST_DRAIN) & (~mem_valid_reg | (ready_go & wb_allowin));
   assign mem_wb_valid = mem_valid_reg & ready_go & ~mem_flush;
   assign fire_wb      = mem_wb_valid & wb_allowin;

   always_comb begin
      result = mem_alu_res;
      case (state_reg)
         ST_WAIT: result = align_wdata;
         ST_HOLD: result = hold_data_reg;
         default: result = mem_alu_res;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         mem_valid_reg <= 1'b0;
      end else if (mem_flush) begin
         mem_valid_reg <= 1'b0;
      end else if (mem_allowin) begin
         mem_valid_reg <= ex_mem_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         hold_data_reg <= '0;
      end else if (capture) begin
         hold_data_reg <= align_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         wb_pc_reg       <= '0;
         wb_inst_reg     <= '0;
         wb_req_rf_reg   <= 1'b0;
         wb_rf_waddr_reg <= '0;
         wb_rf_wdata_reg <= '0;
         wb_flags_reg    <= '0;
         wb_misal_reg    <= 1'b0;
      end else if (fire_wb) begin
         wb_pc_reg       <= mem_pc;
         wb_inst_reg     <= mem_inst;
         wb_req_rf_reg   <= mem_req_rf;
         wb_rf_waddr_reg <= mem_rf_waddr;
         wb_rf_wdata_reg <= result;
         wb_flags_reg    <= ex_flags;
         wb_misal_reg    <= misal;
      end
   end

   assign wb_pc                  = wb_pc_reg;
   assign wb_inst                = wb_inst_reg;
   assign wb_req_rf              = wb_req_rf_reg;
   assign wb_rf_waddr            = wb_rf_waddr_reg;
   assign wb_rf_wdata            = wb_rf_wdata_reg;
   assign mem2wb_exp_flag        = wb_flags_reg.exp_flag;
   assign mem2wb_int_flag        = wb_flags_reg.int_flag;
   assign mem2wb_inst_addr_misal = wb_flags_reg.inst_addr_misal;
   assign mem2wb_illg_inst       = wb_flags_reg.illg_inst;
   assign mem2wb_ecall_inst      = wb_flags_reg.ecall_inst;
   assign mem2wb_ebreak_inst     = wb_flags_reg.ebreak_inst;
   assign mem2wb_load_addr_misal = wb_misal_reg;

endmodule
